// File: rtl/plutox_bus_pkg.sv
// Shared definitions for the CPU data-bus responder: MMIO addresses,
// responder state encoding and status register layout.
package plutox_bus_pkg;

  localparam logic [7:0] ADDR_GPIO = 8'hF0;
  localparam logic [7:0] ADDR_CNT  = 8'hF1;
  localparam logic [7:0] ADDR_STAT = 8'hF2;

  localparam int STAT_ERR_BIT = 0;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x 8 register-file RAM: synchronous write, synchronous clear on reset,
// combinational read port.
module dmem_ram #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [7:0]               wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [7:0]               rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data bus: RAM plus GPIO / cycle counter /
// status MMIO, programmable read latency, sticky bus error flag.
module data_mem_responder
  import plutox_bus_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] address,
  input  logic       mem_read,
  input  logic       mem_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       rd_valid,
  output logic       busy,
  output logic [7:0] gpio_out,
  output logic       bus_err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [7:0] DEPTH_B  = 8'(DEPTH);
  localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 2);

  state_e     state_q;
  logic [1:0] lat_q;
  logic [7:0] snap_q;
  logic [7:0] data_out_q;
  logic       rd_valid_q;
  logic [7:0] gpio_q;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  logic       in_ram, is_gpio, is_cnt, is_stat, unmapped;
  logic       busy_now, rd_acc, wr_acc, err_set, err_clr, ram_we;
  logic [7:0] ram_rdata, rd_data;

  dmem_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .we_i   (ram_we),
    .waddr_i(address[AW-1:0]),
    .wdata_i(data_in),
    .raddr_i(address[AW-1:0]),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    in_ram   = address < DEPTH_B;
    is_gpio  = address == ADDR_GPIO;
    is_cnt   = address == ADDR_CNT;
    is_stat  = address == ADDR_STAT;
    unmapped = !(in_ram || is_gpio || is_cnt || is_stat);

    busy_now = state_q == RD_WAIT;
    wr_acc   = mem_write && !busy_now;
    // A simultaneous read/write strobe keeps only the write.
    rd_acc   = mem_read && !mem_write && !busy_now;
    ram_we   = wr_acc && in_ram;

    err_set  = ((mem_read || mem_write) && busy_now)
            || (mem_read && mem_write)
            || ((rd_acc || wr_acc) && unmapped);
    err_clr  = wr_acc && is_stat && data_in[STAT_ERR_BIT];
    err_d    = err_set || (err_q && !err_clr);
    cnt_d    = cnt_q + 8'd1;

    rd_data = 8'h00;
    if (in_ram) begin
      rd_data = ram_rdata;
    end else if (is_gpio) begin
      rd_data = gpio_q;
    end else if (is_cnt) begin
      rd_data = cnt_q;
    end else if (is_stat) begin
      rd_data[STAT_ERR_BIT] = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lat_q      <= 2'd0;
      snap_q     <= 8'h00;
      data_out_q <= 8'h00;
      rd_valid_q <= 1'b0;
      gpio_q     <= 8'h00;
      cnt_q      <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rd_valid_q <= 1'b0;
      if (wr_acc && is_gpio) begin
        gpio_q <= data_in;
      end
      case (state_q)
        IDLE: begin
          if (rd_acc) begin
            // With unit latency the response is issued straight from the strobe edge.
            if (READ_LATENCY == 1) begin
              rd_valid_q <= 1'b1;
              data_out_q <= rd_data;
            end else begin
              snap_q  <= rd_data;
              lat_q   <= LAT_LOAD;
              state_q <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (lat_q == 2'd0) begin
            rd_valid_q <= 1'b1;
            data_out_q <= snap_q;
            state_q    <= IDLE;
          end else begin
            lat_q <= lat_q - 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_now;
  assign gpio_out = gpio_q;
  assign bus_err  = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: two instances (latency 3 and 4)
// share one stimulus stream; each check names the instance it observes.
module tb_data_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] address;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] data_in;

  logic [7:0] data_out3, gpio_out3, data_out4, gpio_out4;
  logic       rd_valid3, busy3, bus_err3, rd_valid4, busy4, bus_err4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(16), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .address(address), .mem_read(mem_read),
    .mem_write(mem_write), .data_in(data_in), .data_out(data_out3),
    .rd_valid(rd_valid3), .busy(busy3), .gpio_out(gpio_out3), .bus_err(bus_err3)
  );

  data_mem_responder #(.DEPTH(16), .READ_LATENCY(4)) u_dut4 (
    .clk(clk), .reset(reset), .address(address), .mem_read(mem_read),
    .mem_write(mem_write), .data_in(data_in), .data_out(data_out4),
    .rd_valid(rd_valid4), .busy(busy4), .gpio_out(gpio_out4), .bus_err(bus_err4)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h want 0x%02h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    mem_write = 1'b1;
    address   = a;
    data_in   = d;
    step();
    mem_write = 1'b0;
  endtask

  // Read strobe now (cycle N); checks busy over N+1..N+lat-1 and the response
  // in N+lat. Returns positioned in the rd_valid cycle.
  task automatic do_read(input logic [7:0] a, input logic [7:0] exp,
                         input int lat, input string tag);
    mem_read = 1'b1;
    address  = a;
    step();
    mem_read = 1'b0;
    for (int i = 1; i < lat; i++) begin
      chk({tag, " busy"},  (lat == 3) ? busy3 : busy4, 8'h01);
      chk({tag, " early"}, (lat == 3) ? rd_valid3 : rd_valid4, 8'h00);
      step();
    end
    chk({tag, " rd_valid"}, (lat == 3) ? rd_valid3 : rd_valid4, 8'h01);
    chk({tag, " data"},     (lat == 3) ? data_out3 : data_out4, exp);
  endtask

  initial begin
    reset = 1'b1; address = 8'h00; mem_read = 1'b0; mem_write = 1'b0; data_in = 8'h00;
    repeat (3) step();
    reset = 1'b0;

    chk("rst data_out3", data_out3, 8'h00);
    chk("rst rd_valid3", rd_valid3, 8'h00);
    chk("rst busy3",     busy3,     8'h00);
    chk("rst gpio3",     gpio_out3, 8'h00);
    chk("rst err3",      bus_err3,  8'h00);
    chk("rst err4",      bus_err4,  8'h00);

    // Current cycle holds count 0; strobe in cycle 260 sees the wrapped value 4.
    repeat (260) step();
    do_read(8'hF1, 8'h04, 3, "cnt wrap");
    step();
    chk("rd_valid pulse width", rd_valid3, 8'h00);

    bus_wr(8'h03, 8'hA5);
    do_read(8'h03, 8'hA5, 3, "ram03");

    // Write during an in-flight read is dropped and flagged.
    bus_wr(8'h01, 8'h5A);
    mem_read = 1'b1; address = 8'h01;
    step();
    mem_read = 1'b0; mem_write = 1'b1; data_in = 8'h00;
    chk("overrun busy", busy3, 8'h01);
    step();
    mem_write = 1'b0;
    chk("overrun err", bus_err3, 8'h01);
    step();
    chk("overrun rd_valid", rd_valid3, 8'h01);
    chk("overrun old data", data_out3, 8'h5A);
    do_read(8'h01, 8'h5A, 3, "ram01 kept");
    bus_wr(8'hF2, 8'h01);
    chk("w1c clear", bus_err3, 8'h00);

    bus_wr(8'hF0, 8'h3C);
    chk("gpio", gpio_out3, 8'h3C);
    do_read(8'hF0, 8'h3C, 3, "gpio rd");
    do_read(8'h80, 8'h00, 3, "unmapped rd");
    chk("unmapped err", bus_err3, 8'h01);
    do_read(8'hF2, 8'h01, 3, "stat rd");
    bus_wr(8'hF2, 8'h01);
    chk("w1c clear2", bus_err3, 8'h00);

    bus_wr(8'hF1, 8'h55);
    chk("cnt write no err", bus_err3, 8'h00);

    // W1C and a new error in the same cycle: error wins.
    mem_read = 1'b1;
    bus_wr(8'hF2, 8'h01);
    mem_read = 1'b0;
    chk("err precedence", bus_err3, 8'h01);
    bus_wr(8'hF2, 8'h01);

    mem_read = 1'b1;
    bus_wr(8'h05, 8'h77);
    mem_read = 1'b0;
    chk("rdwr err",  bus_err3, 8'h01);
    chk("rdwr busy", busy3,    8'h00);
    for (int i = 0; i < 3; i++) begin
      chk("rdwr no rd_valid", rd_valid3, 8'h00);
      step();
    end
    do_read(8'h05, 8'h77, 3, "ram05");
    bus_wr(8'hF2, 8'h01);

    // Back-to-back reads: second strobe lands in the rd_valid cycle.
    do_read(8'h03, 8'hA5, 3, "b2b first");
    do_read(8'hF0, 8'h3C, 3, "b2b second");
    chk("b2b no err", bus_err3, 8'h00);

    // Address DEPTH is just outside the RAM and must not alias entry 0.
    bus_wr(8'h00, 8'h11);
    bus_wr(8'h0F, 8'h0F);
    bus_wr(8'h10, 8'h99);
    chk("edge wr err", bus_err3, 8'h01);
    do_read(8'h00, 8'h11, 3, "ram00 no alias");
    do_read(8'h0F, 8'h0F, 3, "ram0f");
    do_read(8'h10, 8'h00, 3, "ram10 unmapped");

    // Latency-4 instance: reset abandons an in-flight read.
    repeat (6) step();
    bus_wr(8'h02, 8'h2B);
    bus_wr(8'hF0, 8'hC3);
    chk("l4 gpio", gpio_out4, 8'hC3);
    do_read(8'h02, 8'h2B, 4, "l4 ram02");
    step();
    mem_read = 1'b1; address = 8'h02;
    step();
    mem_read = 1'b0;
    chk("l4 busy before rst", busy4, 8'h01);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("l4 rst data_out", data_out4, 8'h00);
    chk("l4 rst rd_valid", rd_valid4, 8'h00);
    chk("l4 rst busy",     busy4,     8'h00);
    chk("l4 rst gpio",     gpio_out4, 8'h00);
    chk("l4 rst err",      bus_err4,  8'h00);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("l4 abandoned", rd_valid4, 8'h00);
    end
    do_read(8'h02, 8'h00, 4, "l4 ram02 cleared");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
